inv_key_expansion: RTL

INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

---
 rtl/inv_key_expansion.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/inv_key_expansion.sv
// inv_key_expansion: walks the AES-128 key schedule backwards, starting
// from the round-10 key and emitting one round key per accepted handshake
// down to round 0, followed by a single-cycle done pulse.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a schedule (sampled only in IDLE)
//   last_key   round-10 key, w40 at [127:96], w43 at [31:0]
//   key_ready  consumer accepts round_key this cycle
//   busy       high whenever the block is not idle
//   key_valid  round_key / round_idx are valid
//   round_key  current round key, same word order as last_key
//   round_idx  round number of round_key (10 down to 0)
//   done       one-cycle pulse after round 0 has been accepted
//
// state  | meaning
// IDLE   | waiting for start; key register holds its last value
// EMIT   | presenting round_key/round_idx; steps back on each handshake
// FINISH | one-cycle done pulse, then back to IDLE
module inv_key_expansion (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key,
  input  logic         key_ready,
  output logic         busy,
  output logic         key_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    rc = 8'h00;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;

  logic [31:0]  a0, a1, a2, a3;
  logic [31:0]  b0, b1, b2, b3;
  logic [31:0]  rot_b3;
  logic [127:0] prev_key;

  // Undo one forward expansion step. Words 1..3 fall out of the XOR
  // chain directly; word 0 needs the recovered word 3 of the previous key.
  always_comb begin
    a0       = key_q[127:96];
    a1       = key_q[95:64];
    a2       = key_q[63:32];
    a3       = key_q[31:0];
    b3       = a3 ^ a2;
    b2       = a2 ^ a1;
    b1       = a1 ^ a0;
    rot_b3   = {b3[23:0], b3[31:24]};
    b0       = a0 ^ sub_word(rot_b3) ^ {rcon(idx_q), 24'h000000};
    prev_key = {b0, b1, b2, b3};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = last_key;
          idx_d   = 4'd10;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (key_ready) begin
          if (idx_q == 4'd0) begin
            state_d = FINISH;
          end else begin
            key_d = prev_key;
            idx_d = idx_q - 4'd1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign key_valid = (state_q == EMIT);
  assign done      = (state_q == FINISH);
  assign round_key = key_q;
  assign round_idx = idx_q;

endmodule
